mpu_stream_store: RTL
=====================

// Module: mpu_stream_store
// PURPOSE
//  Parametrised successor to the MPU store path. On a store request, reads one whole matrix from
//  mpu_register_file and streams it out one element per handshake on a valid/ready port.
//  Row-major or column-major (transpose) order. Adds size checking and backpressure.
//  Sits between mpu_register_file (read side) and the memory/file writer.
// PARAMETERS
//  FP         32  element width, bits (IEEE-754 single)
//  MAX_M       4  max rows held by a matrix register
//  MAX_N       4  max columns held by a matrix register
//  REG_ABITS   2  register-file address width
//  MW = $clog2(MAX_M)+1, NW = $clog2(MAX_N)+1 (derived; size fields hold value MAX inclusive)
// PORTS
//  clk            in   1                 clock, all logic on posedge
//  rst            in   1                 synchronous, active-low reset
//  en             in   1                 store request strobe (sampled only in IDLE)
//  store_addr     in   REG_ABITS         register to store
//  matrix_m_size  in   MW                rows to stream
//  matrix_n_size  in   NW                columns to stream
//  transpose      in   1                 0 row-major (n fastest), 1 column-major (m fastest)
//  busy           out  1                 high FETCH..STREAM
//  ack            out  1                 1-cycle pulse, transfer complete
//  error          out  1                 1-cycle pulse, request rejected
//  reg_store_en   out  1                 register-file read strobe
//  reg_store_addr out  REG_ABITS         register-file read address
//  reg_matrix_in  in   MAX_M*MAX_N*FP    element [i][j] at bits ((i*MAX_N+j)*FP) +: FP
//  elem_out       out  FP                streamed element
//  elem_m, elem_n out  MW-1 / NW-1       0-based row/column of elem_out
//  elem_valid     out  1                 elem_out valid
//  elem_ready     in   1                 sink accepts
//  elem_last      out  1                 high with final element
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, every output 0, buffer and counters cleared.
//    Applies mid-operation: stream aborted, no ack/error pulse.
//  - FSM: IDLE -> FETCH -> CAPTURE -> STREAM -> DONE -> IDLE; IDLE -> ERR -> IDLE.
//  - IDLE: en=1 latches addr, sizes and transpose. Size 0 or > MAX on either axis -> ERR,
//    otherwise FETCH. en ignored in every other state (no queueing).
//  - ERR: error=1 for one cycle, no register-file access.
//  - FETCH: reg_store_en=1 and reg_store_addr=latched addr for exactly one cycle.
//  - CAPTURE: register file returns data one cycle after reg_store_en. Latch full reg_matrix_in
//    into local buffer. Counters m=n=0.
//  - STREAM: elem_valid=1; elem_out=buf[m][n]; elem_m/elem_n = current index.
//    Advance only on elem_valid&&elem_ready. Outputs held stable while ready=0.
//  - Order: transpose=0 -> n increments, wraps to 0 at n_size-1 with m+1. transpose=1 -> m
//    increments, wraps at m_size-1 with n+1.
//  - elem_last=1 when m==m_size-1 && n==n_size-1. Handshake on last -> DONE.
//  - DONE: ack=1 for one cycle, busy=0, elem_valid=0. Next cycle IDLE.
//  - Timing: en at cycle t -> reg_store_en at t+1 -> capture at t+2 -> first elem_valid at t+3.
//    With ready held high, K=m*n elements occupy t+3..t+2+K and ack is at t+3+K.
//  - Buffer is a snapshot: later register-file writes do not change the stream in flight.
//  - Elements are passed bit-exact; no arithmetic on data.
// TESTING
//  1. 2x2 at addr 0 = {1.0,50.33,-2.5,0.125}, transpose=0, ready=1 -> elem_out 3f800000,424951ec,
//     c0200000,3e000000 at t+3..t+6; last at t+6; ack at t+7.
//  2. Same matrix, transpose=1 -> 3f800000,c0200000,424951ec,3e000000; (m,n)=(0,0),(1,0),(0,1),(1,1).
//  3. 2x3, ready toggled 1,0,0,1,... -> 6 elements in row-major order, none dropped or repeated;
//     data stable while ready=0.
//  4. m_size=0, then n_size=MAX_N+1 -> error pulse 1 cycle each; reg_store_en never asserted;
//     busy stays 0.
//  5. en pulsed during STREAM with a different addr -> ignored; original transfer completes unchanged.
//  6. rst=0 mid-stream after 2 elements -> next cycle all outputs 0, no ack; a new request then
//     runs normally from (0,0).

Source files
------------

// File: rtl/mpu_stream_store.sv
// Matrix store streamer: snapshots one matrix from the register file and emits it one
// element per valid/ready handshake, in row-major or column-major order.
module mpu_stream_store #(
    parameter  int FP        = 32,
    parameter  int MAX_M     = 4,
    parameter  int MAX_N     = 4,
    parameter  int REG_ABITS = 2,
    localparam int MW        = $clog2(MAX_M) + 1,
    localparam int NW        = $clog2(MAX_N) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [REG_ABITS-1:0]      store_addr,
    input  logic [MW-1:0]             matrix_m_size,
    input  logic [NW-1:0]             matrix_n_size,
    input  logic                      transpose,
    output logic                      busy,
    output logic                      ack,
    output logic                      error,
    output logic                      reg_store_en,
    output logic [REG_ABITS-1:0]      reg_store_addr,
    input  logic [MAX_M*MAX_N*FP-1:0] reg_matrix_in,
    output logic [FP-1:0]             elem_out,
    output logic [MW-2:0]             elem_m,
    output logic [NW-2:0]             elem_n,
    output logic                      elem_valid,
    input  logic                      elem_ready,
    output logic                      elem_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_STREAM,
        S_DONE,
        S_ERR
    } state_e;

    // Element [i][j] of the flat register-file word lands at buf[i][j].
    typedef logic [MAX_M-1:0][MAX_N-1:0][FP-1:0] mat_t;

    state_e                 state_q, state_d;
    logic [REG_ABITS-1:0]   addr_q, addr_d;
    logic [MW-1:0]          m_size_q, m_size_d;
    logic [NW-1:0]          n_size_q, n_size_d;
    logic                   tr_q, tr_d;
    mat_t                   buf_q, buf_d;
    logic [MW-2:0]          m_q, m_d;
    logic [NW-2:0]          n_q, n_d;

    logic                   size_ok;
    logic                   m_last;
    logic                   n_last;

    assign size_ok = (matrix_m_size != '0) && (matrix_m_size <= MW'(MAX_M)) &&
                     (matrix_n_size != '0) && (matrix_n_size <= NW'(MAX_N));
    assign m_last  = ({1'b0, m_q} == (m_size_q - MW'(1)));
    assign n_last  = ({1'b0, n_q} == (n_size_q - NW'(1)));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        m_size_d = m_size_q;
        n_size_d = n_size_q;
        tr_d     = tr_q;
        buf_d    = buf_q;
        m_d      = m_q;
        n_d      = n_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    addr_d   = store_addr;
                    m_size_d = matrix_m_size;
                    n_size_d = matrix_n_size;
                    tr_d     = transpose;
                    state_d  = size_ok ? S_FETCH : S_ERR;
                end
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: begin
                buf_d   = reg_matrix_in;
                m_d     = '0;
                n_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (elem_ready) begin
                    if (m_last && n_last) begin
                        state_d = S_DONE;
                    end else if (!tr_q) begin
                        if (n_last) begin
                            n_d = '0;
                            m_d = m_q + (MW-1)'(1);
                        end else begin
                            n_d = n_q + (NW-1)'(1);
                        end
                    end else begin
                        if (m_last) begin
                            m_d = '0;
                            n_d = n_q + (NW-1)'(1);
                        end else begin
                            m_d = m_q + (MW-1)'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state only; outside STREAM the element port reads as zero.
    always_comb begin
        busy           = 1'b0;
        ack            = 1'b0;
        error          = 1'b0;
        reg_store_en   = 1'b0;
        reg_store_addr = '0;
        elem_out       = '0;
        elem_m         = '0;
        elem_n         = '0;
        elem_valid     = 1'b0;
        elem_last      = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy           = 1'b1;
                reg_store_en   = 1'b1;
                reg_store_addr = addr_q;
            end
            S_CAPTURE: busy = 1'b1;
            S_STREAM: begin
                busy       = 1'b1;
                elem_valid = 1'b1;
                elem_out   = buf_q[m_q][n_q];
                elem_m     = m_q;
                elem_n     = n_q;
                elem_last  = m_last && n_last;
            end
            S_DONE:  ack   = 1'b1;
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; next values come from above.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            m_size_q <= '0;
            n_size_q <= '0;
            tr_q     <= 1'b0;
            // NOTE: the snapshot buffer is cleared too, so no pre-reset matrix can resurface.
            buf_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            m_size_q <= m_size_d;
            n_size_q <= n_size_d;
            tr_q     <= tr_d;
            buf_q    <= buf_d;
            m_q      <= m_d;
            n_q      <= n_d;
        end
    end

endmodule
